// File: rtl/csr_pkg.sv
// Shared constants and types for the machine-mode CSR unit: addresses, op
// encoding, status/enable bit positions and the trap sequencer states.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;

    typedef enum logic [1:0] {
        CSR_NONE = 2'b00,
        CSR_RW   = 2'b01,
        CSR_RS   = 2'b10,
        CSR_RC   = 2'b11
    } csr_op_e;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;
    localparam int MIE_MEIE       = 11;
    localparam int MIP_MEIP       = 11;

    localparam logic [31:0] MCAUSE_MEI = 32'h8000_000B;

    typedef enum logic {
        IDLE = 1'b0,
        TRAP = 1'b1
    } trap_state_e;

endpackage

// File: rtl/csr_counter64.sv
// Double-width free-running counter with an increment enable and
// independent half writes; a written half takes the write data, the other
// half keeps the incremented value.
module csr_counter64 #(
    parameter int HALF_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inc_i,
    input  logic                  wr_lo_i,
    input  logic                  wr_hi_i,
    input  logic [HALF_W-1:0]     wdata_i,
    output logic [2*HALF_W-1:0]   cnt_o
);

    logic [2*HALF_W-1:0] cnt_q;
    logic [2*HALF_W-1:0] cnt_inc;
    logic [2*HALF_W-1:0] cnt_d;

    always_comb begin
        cnt_inc = cnt_q + {{(2*HALF_W-1){1'b0}}, inc_i};
        cnt_d   = cnt_inc;
        if (wr_lo_i) cnt_d[HALF_W-1:0]        = wdata_i;
        if (wr_hi_i) cnt_d[2*HALF_W-1:HALF_W] = wdata_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/csr_unit_exe.sv
// Machine-mode CSR file for the EXE stage: CSR read-modify-write, cycle and
// retire counters, external-interrupt trap entry and MRET return.
module csr_unit_exe
    import csr_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        csr_op_EXE,
    input  logic [11:0]       csr_addr_EXE,
    input  logic [DATA_W-1:0] csr_wdata_EXE,
    input  logic              csr_src_zero_EXE,
    input  logic              stall_EXE,
    input  logic [DATA_W-1:0] pc_EXE,
    input  logic              mret_EXE,
    input  logic              retire_valid,
    input  logic              ext_irq,
    output logic [DATA_W-1:0] csr_read_data_EXE,
    output logic              illegal_csr_EXE,
    output logic              trap_taken,
    output logic [DATA_W-1:0] trap_target
);

    localparam logic [DATA_W-1:0] ALIGN_MASK = ~(DATA_W'(3));
    localparam logic [DATA_W-1:0] MCAUSE_VAL = {1'b1, {(DATA_W-5){1'b0}}, 4'hB};

    csr_op_e           op;
    trap_state_e       state_q, state_d;
    logic              mie_q, mpie_q, meie_q;
    logic [DATA_W-1:0] mtvec_q, mepc_q, mcause_q;
    logic [2*DATA_W-1:0] mcycle, minstret;

    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] wval;
    logic              implemented, is_ro, wr_intent, illegal;
    logic              irq_fire, mret_fire, csr_we;

    assign op = csr_op_e'(csr_op_EXE);

    always_comb begin
        rdata       = '0;
        implemented = 1'b1;
        case (csr_addr_EXE)
            CSR_MSTATUS: begin
                rdata[MSTATUS_MIE]                   = mie_q;
                rdata[MSTATUS_MPIE]                  = mpie_q;
                rdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
            end
            CSR_MIE:                   rdata[MIE_MEIE] = meie_q;
            CSR_MTVEC:                 rdata = mtvec_q;
            CSR_MEPC:                  rdata = mepc_q;
            CSR_MCAUSE:                rdata = mcause_q;
            CSR_MIP:                   rdata[MIP_MEIP] = ext_irq;
            CSR_MCYCLE,  CSR_CYCLE:    rdata = mcycle[DATA_W-1:0];
            CSR_MCYCLEH, CSR_CYCLEH:   rdata = mcycle[2*DATA_W-1:DATA_W];
            CSR_MINSTRET:              rdata = minstret[DATA_W-1:0];
            CSR_MINSTRETH:             rdata = minstret[2*DATA_W-1:DATA_W];
            default:                   implemented = 1'b0;
        endcase
    end

    // RS/RC with a zero source are pure reads, so they may target read-only CSRs.
    assign is_ro     = (csr_addr_EXE == CSR_CYCLE) || (csr_addr_EXE == CSR_CYCLEH);
    assign wr_intent = (op == CSR_RW) || !csr_src_zero_EXE;
    assign illegal   = (op != CSR_NONE) && (!implemented || (is_ro && wr_intent));

    assign csr_read_data_EXE = (op == CSR_NONE) ? '0 : rdata;
    assign illegal_csr_EXE   = illegal;

    always_comb begin
        state_d     = state_q;
        irq_fire    = 1'b0;
        mret_fire   = 1'b0;
        case (state_q)
            IDLE: begin
                if (mie_q && meie_q && ext_irq && !stall_EXE) begin
                    irq_fire = 1'b1;
                    state_d  = TRAP;
                end else if (mret_EXE && !stall_EXE) begin
                    mret_fire = 1'b1;
                end
            end
            TRAP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        trap_taken  = irq_fire || mret_fire;
        trap_target = mret_fire ? mepc_q : mtvec_q;
    end

    assign csr_we = (op != CSR_NONE) && wr_intent && !stall_EXE && !illegal && !trap_taken;

    always_comb begin
        case (op)
            CSR_RW:  wval = csr_wdata_EXE;
            CSR_RS:  wval = rdata | csr_wdata_EXE;
            CSR_RC:  wval = rdata & ~csr_wdata_EXE;
            default: wval = rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mie_q    <= 1'b0;
            mpie_q   <= 1'b0;
            meie_q   <= 1'b0;
            mtvec_q  <= RESET_PC & ALIGN_MASK;
            mepc_q   <= '0;
            mcause_q <= '0;
        end else begin
            state_q <= state_d;
            if (irq_fire) begin
                mepc_q   <= pc_EXE & ALIGN_MASK;
                mcause_q <= MCAUSE_VAL;
                mpie_q   <= mie_q;
                mie_q    <= 1'b0;
            end else if (mret_fire) begin
                mie_q  <= mpie_q;
                mpie_q <= 1'b1;
            end else if (csr_we) begin
                case (csr_addr_EXE)
                    CSR_MSTATUS: begin
                        mie_q  <= wval[MSTATUS_MIE];
                        mpie_q <= wval[MSTATUS_MPIE];
                    end
                    CSR_MIE:    meie_q   <= wval[MIE_MEIE];
                    CSR_MTVEC:  mtvec_q  <= wval & ALIGN_MASK;
                    CSR_MEPC:   mepc_q   <= wval & ALIGN_MASK;
                    CSR_MCAUSE: mcause_q <= wval;
                    default: ;
                endcase
            end
        end
    end

    // Counter half writes ride on csr_we; increments never stall.
    csr_counter64 #(.HALF_W(DATA_W)) u_mcycle (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (1'b1),
        .wr_lo_i (csr_we && (csr_addr_EXE == CSR_MCYCLE)),
        .wr_hi_i (csr_we && (csr_addr_EXE == CSR_MCYCLEH)),
        .wdata_i (wval),
        .cnt_o   (mcycle)
    );

    csr_counter64 #(.HALF_W(DATA_W)) u_minstret (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (retire_valid),
        .wr_lo_i (csr_we && (csr_addr_EXE == CSR_MINSTRET)),
        .wr_hi_i (csr_we && (csr_addr_EXE == CSR_MINSTRETH)),
        .wdata_i (wval),
        .cnt_o   (minstret)
    );

endmodule
